matrix_mac4: RTL and testbench
==============================

Name: matrix_mac4

Overview:
- Upstream compute stage of the matrix pipeline. It drives the write-back stage directly through `web` and `MU1`..`MU4`.
- Streams one input vector of K unsigned elements per output column. Each element is multiplied by four coefficients read from an external coefficient ROM, so four dot products are accumulated in parallel.
- Presents the four 18-bit results with a one-cycle `web` pulse, then holds off long enough for write-back to drain its four RAM writes.
- Repeats for N_COL columns per `start`, then signals `done`.

Parameters:
- DW, 8: input element width, unsigned.
- CW, 7: coefficient width, unsigned.
- K, 4: elements per dot product; legal range 1..16.
- N_COL, 16: result groups per `start` (16 groups x 4 words = 64 RAM words).
- RW, 18: result width.
- GAP, 3: idle cycles forced after each `web` pulse.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- x_in  in  DW  input vector element.
- x_valid  in  1  x_in valid.
- x_ready  out  1  block accepts x_in this cycle.
- k_idx  out  4  element index to coefficient ROM.
- col_idx  out  4  column index to coefficient ROM.
- c0, c1, c2, c3  in  CW each  ROM coefficients for (col_idx, k_idx), valid in the same cycle (combinational ROM).
- web  out  1  one-cycle write-back strobe.
- MU1, MU2, MU3, MU4  out  RW each  results; valid while web=1, held until the next EMIT.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc0..acc3=0, MU1..MU4=0.
  - k=0, col=0, gap counter=0.
  - web=0, done=0, x_ready=0.
  - Reset mid-run aborts the run; no partial `web` is produced.
- States: IDLE, ACC, EMIT, WAIT, DONE.
- IDLE:
  - x_ready=0.
  - start=1 -> ACC with acc=0, k=0, col=0.
- ACC:
  - x_ready=1.
  - Accept when x_valid & x_ready; then acc_i <= acc_i + x_in*c_i and k <= k+1.
  - No accept means no change.
  - Accepting with k==K-1 -> EMIT, and the final products are included.
- EMIT (1 cycle):
  - Registered outputs are set: web=1, MU1..MU4 = acc0..acc3.
  - acc is cleared and k=0.
  - Next state: WAIT.
- WAIT:
  - x_ready=0 for GAP cycles. This guarantees at least 4 cycles between web pulses, so write-back never receives a new web while still draining.
  - On exit:
    - If col==N_COL-1 -> DONE.
    - Otherwise col <= col+1 -> ACC.
- DONE:
  - done=1 for 1 cycle.
  - Next state: IDLE.
- Outputs and handshake:
  - web and done are registered and never high simultaneously.
  - k_idx = k and col_idx = col (zero-extended), driven in all states.
  - start while busy=1 is ignored.
  - x_valid while x_ready=0 is ignored; the element is not consumed.
- Arithmetic:
  - Each product is DW+CW bits. Accumulation is done in RW+1 bits.
  - The result saturates at 2^RW-1; it never wraps.
  - With default parameters the maximum is 4*255*127 = 129540, so saturation is unreachable.
- Latency:
  - With x_valid held high, web rises 1 cycle after the K-th accepted element.
  - Column period is K+1+GAP cycles (8 with defaults).
  - A full default run is 128 cycles from the first ACC cycle to the DONE state.

Decomposition:
- Shared package holds:
  - State encodings for IDLE/ACC/EMIT/WAIT/DONE.
  - Width constants DW, CW, RW.
  - The saturation limit constant.
- One natural sub-module, `mac_lane`: a single multiply-accumulate with clear, enable and saturation. Instantiate it four times, one per c_i/acc_i.
- The FSM and counters stay in the top level.

Test Plan:
- Single column (N_COL=1): start; x_in=1,2,3,4 back-to-back; c0..c3 = 1,2,3,4 for every k.
  - Expect web high 1 cycle after the 4th accept with MU1=10, MU2=20, MU3=30, MU4=40.
  - Then 3 WAIT cycles, done pulse, return to IDLE.
- Stalled input: x_valid toggles 1,0,0,1,1,0,1 with x_in=5 and c=1.
  - Expect exactly 4 accepts, MU1=20, and k_idx unchanged across stalls.
- Maximum values: x_in=255, c=127 on all lanes, K=4.
  - Expect MU1..MU4 = 129540 with no saturation.
  - With K=16 (bench override), expect MU = 262143 (saturated).
- Full run, defaults: x_valid=1 continuously.
  - Expect 16 web pulses spaced exactly 8 cycles apart.
  - Expect col_idx stepping 0..15, and done 1 cycle after the last WAIT.
  - Write-back RAM model receives addresses 0..63.
- Protocol: start pulses while busy, and x_valid during WAIT.
  - Expect both ignored: no extra accept, and the web count is unchanged.
- Reset mid-run: assert rst during the 2nd ACC of column 5.
  - Expect web=0, MU=0, state IDLE immediately (asynchronously).
  - A new start restarts at col_idx=0.

Source files
------------

// File: rtl/matrix_mac4_pkg.sv
// matrix_mac4 shared definitions: widths,
// FSM encodings and the saturating add.
package matrix_mac4_pkg;

  localparam int DW = 8;
  localparam int CW = 7;
  localparam int RW = 18;
  localparam int PW = DW + CW;

  localparam logic [RW:0] SAT_MAX =
    {1'b0, {RW{1'b1}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC  = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // acc is never above SAT_MAX, so the
  // RW+1 bit sum cannot itself overflow.
  function automatic logic [RW-1:0] sat_add(
    input logic [RW-1:0] a,
    input logic [PW-1:0] p
  );
    logic [RW:0] s;
    s = {1'b0, a} + {{(RW+1-PW){1'b0}}, p};
    if (s > SAT_MAX) return SAT_MAX[RW-1:0];
    return s[RW-1:0];
  endfunction

endpackage

// File: rtl/matrix_mac4_if.sv
// Stream, coefficient ROM and write-back
// signals of matrix_mac4.
interface matrix_mac4_if;
  import matrix_mac4_pkg::*;

  logic          start;
  logic [DW-1:0] x_in;
  logic          x_valid;
  logic          x_ready;
  logic [3:0]    k_idx;
  logic [3:0]    col_idx;
  logic [CW-1:0] c0, c1, c2, c3;
  logic          web;
  logic [RW-1:0] MU1, MU2, MU3, MU4;
  logic          busy;
  logic          done;

  modport master (
    output start, x_in, x_valid,
    output c0, c1, c2, c3,
    input  x_ready, k_idx, col_idx,
    input  web, MU1, MU2, MU3, MU4,
    input  busy, done
  );

  modport slave (
    input  start, x_in, x_valid,
    input  c0, c1, c2, c3,
    output x_ready, k_idx, col_idx,
    output web, MU1, MU2, MU3, MU4,
    output busy, done
  );

endinterface

// File: rtl/matrix_mac4_mac_lane.sv
// One saturating multiply-accumulate lane;
// clear wins over enable.
module mac_lane
  import matrix_mac4_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] x_i,
  input  logic [CW-1:0] c_i,
  output logic [RW-1:0] acc_o
);

  logic [RW-1:0] acc_q, acc_d;
  logic [PW-1:0] prod;

  assign prod = {{CW{1'b0}}, x_i}
              * {{DW{1'b0}}, c_i};

  // next accumulator value
  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sat_add(acc_q, prod);
  end

  // accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mac4.sv
// Four-lane dot-product stage feeding the
// write-back RAM, one column per web pulse.
module matrix_mac4
  import matrix_mac4_pkg::*;
#(
  parameter int K     = 4,
  parameter int N_COL = 16,
  parameter int GAP   = 3
) (
  input logic          clk,
  input logic          rst,
  matrix_mac4_if.slave bus
);

  logic [2:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [3:0] col_q, col_d;
  logic [3:0] gap_q, gap_d;
  logic       web_q, web_d;
  logic       done_q, done_d;
  logic       clr, accept;
  logic       last_k, last_col, last_gap;

  logic [3:0][CW-1:0] c_vec;
  logic [3:0][RW-1:0] acc;
  logic [3:0][RW-1:0] mu_q;

  assign c_vec = {bus.c3, bus.c2,
                  bus.c1, bus.c0};

  assign accept   = (state_q == S_ACC)
                  && bus.x_valid;
  assign last_k   = k_q   == 4'(K - 1);
  assign last_col = col_q == 4'(N_COL - 1);
  assign last_gap = gap_q == 4'(GAP - 1);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mac_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .en_i  (accept),
      .x_i   (bus.x_in),
      .c_i   (c_vec[i]),
      .acc_o (acc[i])
    );
  end

  // sequencing: accumulate, emit, drain gap
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    col_d   = col_q;
    gap_d   = gap_q;
    web_d   = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACC;
          k_d     = '0;
          col_d   = '0;
          clr     = 1'b1;
        end
      end
      S_ACC: begin
        if (accept) begin
          if (last_k) begin
            state_d = S_EMIT;
            k_d     = '0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_EMIT: begin
        web_d   = 1'b1;
        clr     = 1'b1;
        k_d     = '0;
        gap_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!last_gap) begin
          gap_d = gap_q + 4'd1;
        end else if (last_col) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          col_d   = col_q + 4'd1;
          state_d = S_ACC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      col_q   <= '0;
      gap_q   <= '0;
      web_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      web_q   <= web_d;
      done_q  <= done_d;
    end
  end

  // result latch, held until the next emit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    mu_q <= '0;
    else if (state_q == S_EMIT) mu_q <= acc;
  end

  assign bus.x_ready = state_q == S_ACC;
  assign bus.busy    = state_q != S_IDLE;
  assign bus.k_idx   = k_q;
  assign bus.col_idx = col_q;
  assign bus.web     = web_q;
  assign bus.done    = done_q;
  assign bus.MU1     = mu_q[0];
  assign bus.MU2     = mu_q[1];
  assign bus.MU3     = mu_q[2];
  assign bus.MU4     = mu_q[3];

endmodule

// File: tb/tb_matrix_mac4.sv
// Directed bench for matrix_mac4: vector
// table, stalls, saturation, full run, reset.
module tb_matrix_mac4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  matrix_mac4_if one_if ();
  matrix_mac4_if k16_if ();
  matrix_mac4_if def_if ();

  matrix_mac4 #(.K(4), .N_COL(1), .GAP(3))
    u_one (.clk(clk), .rst(rst), .bus(one_if));
  matrix_mac4 #(.K(16), .N_COL(1), .GAP(3))
    u_k16 (.clk(clk), .rst(rst), .bus(k16_if));
  matrix_mac4
    u_def (.clk(clk), .rst(rst), .bus(def_if));

  typedef struct packed {
    logic [3:0][7:0]  x;
    logic [3:0][6:0]  c;
    logic [3:0][17:0] mu;
  } vec_t;

  vec_t tbl[5];

  function automatic int xf(int k, int col);
    return k * 40 + col * 3 + 1;
  endfunction

  function automatic int cf(int i, int k,
                            int col);
    case (i)
      0:       return col + 1;
      1:       return k * 30 + 7;
      2:       return col * 8 + k;
      default: return 127 - 2 * col * k;
    endcase
  endfunction

  function automatic int expmu(int i, int col);
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += xf(k, col) * cf(i, k, col);
    return (s > 262143) ? 262143 : s;
  endfunction

  function automatic vec_t mkv(
    int x0, int x1, int x2, int x3,
    int c0, int c1, int c2, int c3,
    int m0, int m1, int m2, int m3);
    vec_t v;
    v.x  = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    v.c  = {7'(c3), 7'(c2), 7'(c1), 7'(c0)};
    v.mu = {18'(m3), 18'(m2),
            18'(m1), 18'(m0)};
    return v;
  endfunction

  // combinational coefficient ROM and
  // element source for the default instance
  always_comb begin
    def_if.x_in = 8'(xf(int'(def_if.k_idx),
                        int'(def_if.col_idx)));
    def_if.c0 = 7'(cf(0, int'(def_if.k_idx),
                      int'(def_if.col_idx)));
    def_if.c1 = 7'(cf(1, int'(def_if.k_idx),
                      int'(def_if.col_idx)));
    def_if.c2 = 7'(cf(2, int'(def_if.k_idx),
                      int'(def_if.col_idx)));
    def_if.c3 = 7'(cf(3, int'(def_if.k_idx),
                      int'(def_if.col_idx)));
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits for web on one_if, then checks the
  // results and the gap up to done
  task automatic one_finish(input vec_t v,
                            input int nmu);
    int lat = 0;
    while (!one_if.web && lat < 12) begin
      tick();
      lat++;
    end
    chk("web_latency", lat, 1);
    chk("MU1", 32'(one_if.MU1), 32'(v.mu[0]));
    if (nmu > 1) begin
      chk("MU2", 32'(one_if.MU2), 32'(v.mu[1]));
      chk("MU3", 32'(one_if.MU3), 32'(v.mu[2]));
      chk("MU4", 32'(one_if.MU4), 32'(v.mu[3]));
    end
    lat = 0;
    while (!one_if.done && lat < 12) begin
      tick();
      lat++;
      if (one_if.web)
        chk("web_width", 32'(one_if.web), 0);
    end
    chk("web_to_done", lat, 3);
    tick();
    chk("idle_after_done",
        32'(one_if.busy), 0);
  endtask

  task automatic run_one(input vec_t v);
    one_if.c0 = v.c[0];
    one_if.c1 = v.c[1];
    one_if.c2 = v.c[2];
    one_if.c3 = v.c[3];
    one_if.start = 1'b1;
    tick();
    one_if.start = 1'b0;
    one_if.x_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      one_if.x_in = v.x[i];
      tick();
    end
    one_if.x_valid = 1'b0;
    one_finish(v, 4);
  endtask

  logic [17:0] ram[64];
  int nweb, last_web, first_web, done_cyc;
  int acc_cnt, ramwr, lat;
  bit pat[7];

  initial begin
    one_if.start = 0; one_if.x_valid = 0;
    one_if.x_in = 0;
    one_if.c0 = 0; one_if.c1 = 0;
    one_if.c2 = 0; one_if.c3 = 0;
    k16_if.start = 0; k16_if.x_valid = 0;
    k16_if.x_in = 0;
    k16_if.c0 = 0; k16_if.c1 = 0;
    k16_if.c2 = 0; k16_if.c3 = 0;
    def_if.start = 0; def_if.x_valid = 0;

    tbl[0] = mkv(1, 2, 3, 4, 1, 2, 3, 4,
                 10, 20, 30, 40);
    tbl[1] = mkv(255, 255, 255, 255,
                 127, 127, 127, 127,
                 129540, 129540, 129540, 129540);
    tbl[2] = mkv(0, 0, 0, 0, 5, 6, 7, 8,
                 0, 0, 0, 0);
    tbl[3] = mkv(3, 0, 7, 1, 2, 9, 100, 127,
                 22, 99, 1100, 1397);
    tbl[4] = mkv(200, 100, 50, 25, 0, 1, 0, 64,
                 0, 375, 0, 24000);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_web", 32'(def_if.web), 0);
    chk("rst_busy", 32'(def_if.busy), 0);
    chk("rst_x_ready", 32'(def_if.x_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_MU1", 32'(def_if.MU1), 0);
    chk("idle_done", 32'(def_if.done), 0);
    chk("idle_k_idx", 32'(def_if.k_idx), 0);
    chk("idle_col", 32'(def_if.col_idx), 0);
    chk("idle_x_ready", 32'(def_if.x_ready), 0);

    for (int t = 0; t < 5; t++) run_one(tbl[t]);

    // stalled stream, k only moves on accept
    pat = '{1, 0, 0, 1, 1, 0, 1};
    one_if.c0 = 1; one_if.c1 = 1;
    one_if.c2 = 1; one_if.c3 = 1;
    one_if.x_in = 8'd5;
    one_if.start = 1'b1;
    tick();
    one_if.start = 1'b0;
    begin
      int kexp = 0;
      for (int i = 0; i < 7; i++) begin
        one_if.x_valid = pat[i];
        chk("stall_x_ready",
            32'(one_if.x_ready), 1);
        tick();
        if (pat[i]) kexp = (kexp + 1) % 4;
        chk("stall_k_idx",
            32'(one_if.k_idx), kexp);
      end
    end
    one_if.x_valid = 1'b0;
    one_finish(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                   20, 0, 0, 0), 1);

    // K=16 at full scale saturates
    k16_if.c0 = 127; k16_if.c1 = 127;
    k16_if.c2 = 127; k16_if.c3 = 127;
    k16_if.x_in = 8'd255;
    k16_if.start = 1'b1;
    tick();
    k16_if.start = 1'b0;
    k16_if.x_valid = 1'b1;
    repeat (16) tick();
    k16_if.x_valid = 1'b0;
    lat = 0;
    while (!k16_if.web && lat < 12) begin
      tick();
      lat++;
    end
    chk("k16_latency", lat, 1);
    chk("k16_MU1", 32'(k16_if.MU1), 262143);
    chk("k16_MU2", 32'(k16_if.MU2), 262143);
    chk("k16_MU3", 32'(k16_if.MU3), 262143);
    chk("k16_MU4", 32'(k16_if.MU4), 262143);

    // full default run; x_valid stays high
    // through WAIT and start is re-pulsed
    nweb = 0; last_web = 0; first_web = -1;
    done_cyc = -1; acc_cnt = 0; ramwr = 0;
    def_if.x_valid = 1'b1;
    def_if.start = 1'b1;
    tick();
    def_if.start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (def_if.x_valid && def_if.x_ready)
        acc_cnt++;
      if (def_if.web) begin
        if (nweb == 0) first_web = cyc;
        else chk("web_spacing",
                 cyc - last_web, 8);
        chk("web_col_idx",
            32'(def_if.col_idx), nweb);
        chk("run_MU1", 32'(def_if.MU1),
            expmu(0, nweb));
        chk("run_MU2", 32'(def_if.MU2),
            expmu(1, nweb));
        chk("run_MU3", 32'(def_if.MU3),
            expmu(2, nweb));
        chk("run_MU4", 32'(def_if.MU4),
            expmu(3, nweb));
        for (int j = 0; j < 4; j++) begin
          if (nweb * 4 + j < 64) begin
            ram[nweb * 4 + j] =
              (j == 0) ? def_if.MU1 :
              (j == 1) ? def_if.MU2 :
              (j == 2) ? def_if.MU3 :
                         def_if.MU4;
            ramwr++;
          end
        end
        last_web = cyc;
        nweb++;
      end
      if (def_if.done) begin
        done_cyc = cyc;
        break;
      end
      def_if.start = (cyc == 20 || cyc == 61);
    end
    def_if.start = 1'b0;
    chk("first_web_cyc", first_web, 5);
    chk("done_cyc", done_cyc, 128);
    chk("last_web_to_done",
        done_cyc - last_web, 3);
    chk("web_count", nweb, 16);
    chk("accept_count", acc_cnt, 64);
    chk("ram_writes", ramwr, 64);
    chk("ram_last", 32'(ram[63]), expmu(3, 15));
    tick();
    chk("done_width", 32'(def_if.done), 0);
    chk("run_idle", 32'(def_if.busy), 0);

    // reset in the 2nd ACC cycle of column 5
    def_if.start = 1'b1;
    tick();
    def_if.start = 1'b0;
    lat = 0;
    while (!(def_if.col_idx == 4'd5
             && def_if.k_idx == 4'd1)
           && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("reach_col5", 32'(lat < 100), 1);
    chk("pre_rst_MU1", 32'(def_if.MU1),
        expmu(0, 4));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_web", 32'(def_if.web), 0);
    chk("arst_MU1", 32'(def_if.MU1), 0);
    chk("arst_MU4", 32'(def_if.MU4), 0);
    chk("arst_busy", 32'(def_if.busy), 0);
    chk("arst_col", 32'(def_if.col_idx), 0);
    chk("arst_x_ready",
        32'(def_if.x_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    def_if.start = 1'b1;
    tick();
    def_if.start = 1'b0;
    chk("restart_col", 32'(def_if.col_idx), 0);
    chk("restart_k", 32'(def_if.k_idx), 0);
    chk("restart_busy", 32'(def_if.busy), 1);
    lat = 0;
    while (!def_if.web && lat < 20) begin
      tick();
      lat++;
    end
    chk("restart_latency", lat, 5);
    chk("restart_MU1", 32'(def_if.MU1),
        expmu(0, 0));
    chk("restart_MU3", 32'(def_if.MU3),
        expmu(2, 0));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
